// File: rtl/inst_encoder_3r.sv
// ============================================================================
//  inst_encoder_3r
//  Encodes LoongArch 3R-format (plus shift-imm, BREAK, SYSCALL) instructions
//  from internal op codes, delivered through a 2-entry valid/ready skid buffer.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_encoder_3r #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_op,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rj,
  input  logic [4:0]           in_rk,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_inst,
  output logic                 err_invalid,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // Internal op codes shared with the decode path
  localparam logic [7:0] OP_INVALID = 8'd0;
  localparam logic [7:0] OP_ADD     = 8'd1;
  localparam logic [7:0] OP_SUB     = 8'd2;
  localparam logic [7:0] OP_SLT     = 8'd3;
  localparam logic [7:0] OP_SLTU    = 8'd4;
  localparam logic [7:0] OP_NOR     = 8'd5;
  localparam logic [7:0] OP_AND     = 8'd6;
  localparam logic [7:0] OP_OR      = 8'd7;
  localparam logic [7:0] OP_XOR     = 8'd8;
  localparam logic [7:0] OP_SLL     = 8'd9;
  localparam logic [7:0] OP_SRL     = 8'd10;
  localparam logic [7:0] OP_SRA     = 8'd11;
  localparam logic [7:0] OP_MUL     = 8'd12;
  localparam logic [7:0] OP_MULH    = 8'd13;
  localparam logic [7:0] OP_MULHU   = 8'd14;
  localparam logic [7:0] OP_DIV     = 8'd15;
  localparam logic [7:0] OP_MOD     = 8'd16;
  localparam logic [7:0] OP_DIVU    = 8'd17;
  localparam logic [7:0] OP_MODU    = 8'd18;
  localparam logic [7:0] OP_BREAK   = 8'd19;
  localparam logic [7:0] OP_SYSCALL = 8'd20;
  localparam logic [7:0] OP_SLLI    = 8'd21;
  localparam logic [7:0] OP_SRLI    = 8'd22;
  localparam logic [7:0] OP_SRAI    = 8'd23;

  logic [1:0]           cnt_q, cnt_d;
  logic [31:0]          ent0_q, ent0_d;
  logic [31:0]          ent1_q, ent1_d;
  logic                 in_ready_q;
  logic                 err_invalid_q;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [7:0]  opf_w;
  logic        op_ok_w;
  logic [31:0] enc_w;
  logic        accept_w, push_w, pop_w, drop_w;

  always_comb begin
    opf_w   = 8'h00;
    op_ok_w = 1'b1;
    case (in_op)
      OP_ADD:     opf_w = 8'h20;
      OP_SUB:     opf_w = 8'h22;
      OP_SLT:     opf_w = 8'h24;
      OP_SLTU:    opf_w = 8'h25;
      OP_NOR:     opf_w = 8'h28;
      OP_AND:     opf_w = 8'h29;
      OP_OR:      opf_w = 8'h2A;
      OP_XOR:     opf_w = 8'h2B;
      OP_SLL:     opf_w = 8'h2E;
      OP_SRL:     opf_w = 8'h2F;
      OP_SRA:     opf_w = 8'h30;
      OP_MUL:     opf_w = 8'h38;
      OP_MULH:    opf_w = 8'h39;
      OP_MULHU:   opf_w = 8'h3A;
      OP_DIV:     opf_w = 8'h40;
      OP_MOD:     opf_w = 8'h41;
      OP_DIVU:    opf_w = 8'h42;
      OP_MODU:    opf_w = 8'h43;
      OP_BREAK:   opf_w = 8'h54;
      OP_SYSCALL: opf_w = 8'h56;
      OP_SLLI:    opf_w = 8'h81;
      OP_SRLI:    opf_w = 8'h89;
      OP_SRAI:    opf_w = 8'h91;
      OP_INVALID: op_ok_w = 1'b0;
      default:    op_ok_w = 1'b0;
    endcase
  end

  assign enc_w    = {9'b0, opf_w, in_rk, in_rj, in_rd};
  assign accept_w = in_valid & in_ready_q;
  assign push_w   = accept_w & op_ok_w;
  assign drop_w   = accept_w & ~op_ok_w;
  assign pop_w    = (cnt_q != 2'd0) & out_ready;

  // Entry 0 is always the head; a pop shifts entry 1 down.
  always_comb begin
    cnt_d  = cnt_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else if (push_w && pop_w) begin
      ent0_d = enc_w;
    end else if (push_w) begin
      if (cnt_q == 2'd0) ent0_d = enc_w;
      else               ent1_d = enc_w;
      cnt_d = cnt_q + 2'd1;
    end else if (pop_w) begin
      ent0_d = ent1_q;
      cnt_d  = cnt_q - 2'd1;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (drop_w && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q         <= 2'd0;
      ent0_q        <= 32'h0;
      ent1_q        <= 32'h0;
      in_ready_q    <= 1'b0;
      err_invalid_q <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      cnt_q         <= cnt_d;
      ent0_q        <= ent0_d;
      ent1_q        <= ent1_d;
      in_ready_q    <= (cnt_d != 2'd2);
      err_invalid_q <= drop_w;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (cnt_q != 2'd0);
  assign out_inst    = ent0_q;
  assign err_invalid = err_invalid_q;
  assign err_cnt     = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder_3r.sv
// ============================================================================
//  tb_inst_encoder_3r
//  Scoreboard bench for inst_encoder_3r; second instance checks saturation.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_encoder_3r;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_op = 8'd0;
  logic [4:0]  in_rd = 5'd0, in_rj = 5'd0, in_rk = 5'd0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, err_invalid;
  logic [31:0] out_inst;
  logic [15:0] err_cnt;
  logic        s_in_ready, s_out_valid, s_err_invalid;
  logic [31:0] s_out_inst;
  logic [1:0]  s_err_cnt;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] sb_q[$];
  logic        exp_rdy   = 1'b0;
  logic        exp_pulse = 1'b0;
  int          exp_cnt   = 0;
  int          exp_cnt2  = 0;
  logic        last_acc  = 1'b0;
  logic        rnd_ready = 1'b0;

  inst_encoder_3r #(.ERR_CNT_W(16)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rj(in_rj), .in_rk(in_rk),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .err_invalid(err_invalid), .err_cnt(err_cnt)
  );

  inst_encoder_3r #(.ERR_CNT_W(2)) dut_sat (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_op(in_op),
    .in_rd(in_rd), .in_rj(in_rj), .in_rk(in_rk),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_inst(s_out_inst),
    .err_invalid(s_err_invalid), .err_cnt(s_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, act, exp);
    end
  endtask

  // Reference encoding taken directly from the opcode table
  function automatic logic [32:0] ref_enc(input logic [7:0] op, input logic [4:0] rd,
                                          input logic [4:0] rj, input logic [4:0] rk);
    logic [7:0] f;
    logic       ok;
    ok = 1'b1;
    case (op)
      8'd1: f = 8'h20;  8'd2: f = 8'h22;  8'd3: f = 8'h24;  8'd4: f = 8'h25;
      8'd5: f = 8'h28;  8'd6: f = 8'h29;  8'd7: f = 8'h2A;  8'd8: f = 8'h2B;
      8'd9: f = 8'h2E;  8'd10: f = 8'h2F; 8'd11: f = 8'h30; 8'd12: f = 8'h38;
      8'd13: f = 8'h39; 8'd14: f = 8'h3A; 8'd15: f = 8'h40; 8'd16: f = 8'h41;
      8'd17: f = 8'h42; 8'd18: f = 8'h43; 8'd19: f = 8'h54; 8'd20: f = 8'h56;
      8'd21: f = 8'h81; 8'd22: f = 8'h89; 8'd23: f = 8'h91;
      default: begin f = 8'h00; ok = 1'b0; end
    endcase
    return {ok, 9'b0, f, rk, rj, rd};
  endfunction

  // One clock: check at negedge, update model, advance to posedge+1.
  task automatic cycle();
    logic [32:0] e;
    logic        acc;
    @(negedge clk);
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    chk("out_valid", {31'b0, out_valid}, {31'b0, sb_q.size() != 0});
    if (out_valid && sb_q.size() != 0) chk("out_inst", out_inst, sb_q[0]);
    chk("err_invalid", {31'b0, err_invalid}, {31'b0, exp_pulse});
    chk("err_cnt", {16'b0, err_cnt}, exp_cnt);
    chk("err_cnt_sat", {30'b0, s_err_cnt}, exp_cnt2);
    e   = ref_enc(in_op, in_rd, in_rj, in_rk);
    acc = in_valid & exp_rdy;
    if (out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
    if (acc && e[32]) sb_q.push_back(e[31:0]);
    if (flush) sb_q.delete();
    exp_pulse = acc & ~e[32];
    if (exp_pulse) begin
      if (exp_cnt < 65535) exp_cnt++;
      if (exp_cnt2 < 3) exp_cnt2++;
    end
    exp_rdy  = (sb_q.size() != 2);
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [7:0] op, input logic [4:0] rd, input logic [4:0] rj,
                         input logic [4:0] rk);
    int tries;
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rj = rj; in_rk = rk;
    tries = 0;
    do begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      tries++;
    end while (!last_acc && tries < 200);
    if (!last_acc) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic model_reset();
    sb_q.delete();
    exp_rdy = 1'b0; exp_pulse = 1'b0; exp_cnt = 0; exp_cnt2 = 0;
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_err_cnt", {16'b0, err_cnt}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    cycle();
    chk("rdy_after_rst", {31'b0, in_ready}, 32'd1);

    // Directed encodings, 1-cycle latency into an empty buffer
    out_ready = 1'b1;
    push_op(8'd1, 5'd3, 5'd4, 5'd5);
    chk("add_word", out_inst, 32'h00101483);
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    push_op(8'd23, 5'd1, 5'd2, 5'd31);
    chk("srai_word", out_inst, 32'h0048FC41);
    push_op(8'd20, 5'h11, 5'd0, 5'd0);
    chk("syscall_word", out_inst, 32'h002B0011);
    push_op(8'd19, 5'd0, 5'd0, 5'd0);
    chk("break_word", out_inst, 32'h002A0000);
    cycle();
    chk("drained", {31'b0, out_valid}, 32'd0);

    // Backpressure: third request held until the consumer drains
    out_ready = 1'b0;
    push_op(8'd2, 5'd1, 5'd2, 5'd3);
    push_op(8'd6, 5'd4, 5'd5, 5'd6);
    chk("full_rdy_low", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b1; in_op = 8'd12; in_rd = 5'd7; in_rj = 5'd8; in_rk = 5'd9;
    cycle();
    cycle();
    chk("third_held", {31'b0, last_acc}, 32'd0);
    out_ready = 1'b1;
    push_op(8'd12, 5'd7, 5'd8, 5'd9);
    repeat (4) cycle();
    chk("bp_empty", sb_q.size(), 32'd0);

    // Invalid op then ADD: pulse, count, only ADD emerges
    push_op(8'd0, 5'd1, 5'd1, 5'd1);
    cycle();
    push_op(8'd1, 5'd9, 5'd10, 5'd11);
    cycle();
    chk("err_cnt_one", {16'b0, err_cnt}, 32'd1);

    // Saturation on the narrow instance
    repeat (4) push_op(8'd200, 5'd0, 5'd0, 5'd0);
    cycle();
    chk("sat_cnt", {30'b0, s_err_cnt}, 32'd3);
    chk("wide_cnt", {16'b0, err_cnt}, 32'd5);

    // Flush with two buffered and a same-cycle push
    out_ready = 1'b0;
    push_op(8'd3, 5'd1, 5'd1, 5'd1);
    push_op(8'd4, 5'd2, 5'd2, 5'd2);
    cycle();
    in_valid = 1'b1; in_op = 8'd5;
    flush = 1'b1;
    exp_rdy = exp_rdy;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    repeat (3) cycle();

    // Async reset mid-stream with entries buffered
    out_ready = 1'b0;
    push_op(8'd7, 5'd1, 5'd2, 5'd3);
    push_op(8'd8, 5'd4, 5'd5, 5'd6);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_rdy", {31'b0, in_ready}, 32'd0);
    chk("mid_rst_inst", out_inst, 32'd0);
    chk("mid_rst_errcnt", {16'b0, err_cnt}, 32'd0);
    model_reset();
    @(posedge clk); #1;
    resetn = 1'b1;
    out_ready = 1'b1;
    cycle();
    cycle();

    // Random traffic with random backpressure against the reference
    rnd_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      logic [7:0] op;
      op = ($urandom_range(0, 24) == 0) ? 8'd0 : 8'($urandom_range(1, 23));
      if ($urandom_range(0, 3) == 0) begin
        out_ready = ($urandom_range(0, 3) != 0);
        cycle();
      end
      push_op(op, 5'($urandom), 5'($urandom), 5'($urandom));
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    repeat (4) cycle();
    chk("final_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
